// File: rtl/pipelined_bcla_adder_if.sv
// Operand/result handshake bundle for pipelined_bcla_adder.
// The ovf signal exists only when BCLA_OVF_EN is defined.
interface pipelined_bcla_adder_if #(
  parameter int WIDTH = 19
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;
`ifdef BCLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, s
`ifdef BCLA_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, s
`ifdef BCLA_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/pipelined_bcla_adder.sv
// 3-stage pipelined two-level block carry look-ahead adder, s = x + y + cin.
// Define BCLA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_bcla_adder #(
  parameter int WIDTH = 19,
  parameter int BLOCK = 4,
  parameter int GROUP = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_bcla_adder_if.slave bus
);
  localparam int NB = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int NG = (NB + GROUP - 1) / GROUP;

  // Handshake: a beat moves on a rising edge when valid & ready are both high.
  // adv is the global advance; in_ready = adv, so no stage ever holds a beat alone.
  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;

  logic [WIDTH-1:0] p_in, g_in;
  logic [NB-1:0]    gb_c, pb_c;
  assign p_in = bus.x ^ bus.y;
  assign g_in = bus.x & bus.y;

  // Positions past WIDTH are simply skipped, which is the same as P=1, G=0.
  always_comb begin : blk_gp
    logic gacc, pacc;
    gb_c = '0;
    pb_c = '0;
    for (int j = 0; j < NB; j++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int b = 0; b < BLOCK; b++) begin
        if (j * BLOCK + b < WIDTH) begin
          gacc = g_in[j*BLOCK+b] | (p_in[j*BLOCK+b] & gacc);
          pacc = pacc & p_in[j*BLOCK+b];
        end
      end
      gb_c[j] = gacc;
      pb_c[j] = pacc;
    end
  end

  logic             v1, cin1;
  logic [WIDTH-1:0] p1, g1;
  logic [NB-1:0]    gb1, pb1;

  logic [NB-1:0] cb_c;
  logic          cout_c;

  always_comb begin : blk_carry
    logic       gg, pg, cc;
    logic [NG:0] cgrp;
    cb_c    = '0;
    cgrp    = '0;
    cgrp[0] = cin1;
    for (int k = 0; k < NG; k++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int b = 0; b < GROUP; b++) begin
        if (k * GROUP + b < NB) begin
          gg = gb1[k*GROUP+b] | (pb1[k*GROUP+b] & gg);
          pg = pg & pb1[k*GROUP+b];
        end
      end
      cgrp[k+1] = gg | (pg & cgrp[k]);
    end
    // Block carries inside each group are seeded from that group's carry-in.
    for (int k = 0; k < NG; k++) begin
      cc = cgrp[k];
      for (int b = 0; b < GROUP; b++) begin
        if (k * GROUP + b < NB) begin
          cb_c[k*GROUP+b] = cc;
          cc = gb1[k*GROUP+b] | (pb1[k*GROUP+b] & cc);
        end
      end
    end
    cout_c = cgrp[NG];
  end

  logic             v2, cout2;
  logic [WIDTH-1:0] p2, g2;
  logic [NB-1:0]    cb2;

  logic [WIDTH-1:0] c3;
  logic [WIDTH-1:0] sum_c;

  always_comb begin : blk_ripple
    logic cc;
    c3 = '0;
    for (int j = 0; j < NB; j++) begin
      cc = cb2[j];
      for (int b = 0; b < BLOCK; b++) begin
        if (j * BLOCK + b < WIDTH) begin
          c3[j*BLOCK+b] = cc;
          cc = g2[j*BLOCK+b] | (p2[j*BLOCK+b] & cc);
        end
      end
    end
  end
  assign sum_c = p2 ^ c3;

  logic           v3;
  logic [WIDTH:0] s3;
`ifdef BCLA_OVF_EN
  logic           ovf3;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      cin1  <= 1'b0;
      p1    <= '0;
      g1    <= '0;
      gb1   <= '0;
      pb1   <= '0;
      v2    <= 1'b0;
      cout2 <= 1'b0;
      p2    <= '0;
      g2    <= '0;
      cb2   <= '0;
      v3    <= 1'b0;
      s3    <= '0;
`ifdef BCLA_OVF_EN
      ovf3  <= 1'b0;
`endif
    end else if (adv) begin
      v1    <= bus.in_valid;
      cin1  <= bus.cin;
      p1    <= p_in;
      g1    <= g_in;
      gb1   <= gb_c;
      pb1   <= pb_c;
      v2    <= v1;
      cout2 <= cout_c;
      p2    <= p1;
      g2    <= g1;
      cb2   <= cb_c;
      v3    <= v2;
      // Bubbles leave the last result on s untouched.
      if (v2) begin
        s3   <= {cout2, sum_c};
`ifdef BCLA_OVF_EN
        ovf3 <= c3[WIDTH-1] ^ cout2;
`endif
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v3;
  assign bus.s         = s3;
`ifdef BCLA_OVF_EN
  assign bus.ovf       = ovf3;
`endif
endmodule
